// File: rtl/opcodes.sv
// picoMIPS opcode encodings shared by the decoder, the program-load encoder and their benches.
`ifndef OPCODES_SV
`define OPCODES_SV
`define NOP  6'b000000
`define ADD  6'b000001
`define ADDI 6'b000010
`define LDI  6'b000011
`endif

// File: rtl/instr_encoder.sv
// picoMIPS program-load encoder: packs handshaked instruction fields into 20-bit words,
// buffers them in a small FIFO and writes them to program memory from address 0.
`include "opcodes.sv"

module instr_encoder #(
  parameter int unsigned PSIZE = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_opcode,
  input  logic [2:0]       in_rd,
  input  logic [2:0]       in_rs,
  input  logic [7:0]       in_imm,
  input  logic             in_last,
  output logic             pm_we,
  input  logic             pm_ready,
  output logic [PSIZE-1:0] pm_addr,
  output logic [19:0]      pm_wdata,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             illegal,
  output logic [7:0]       err_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]       PTR_ONE  = 1;
  localparam logic [PSIZE-1:0]  ADDR_ONE = 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t      state, state_nxt;
  logic [19:0] fifo [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        fifo_full, fifo_empty, one_left;
  logic        push, pop, last_seen, addr_max, session_start;
  logic        is_illegal;
  logic [19:0] enc_word;

  assign fifo_empty    = (wptr == rptr);
  assign fifo_full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign one_left      = ((wptr - rptr) == PTR_ONE);
  assign addr_max      = (pm_addr == '1);
  assign session_start = start && (state != LOAD);

  // Fullness comes from registered pointers only, so a same-cycle pop never frees a slot.
  assign in_ready = (state == LOAD) && !fifo_full && !last_seen && !ovf;
  assign push     = in_valid && in_ready;
  assign pm_we    = !fifo_empty && (state == LOAD);
  assign pop      = pm_we && pm_ready;
  assign pm_wdata = pm_we ? fifo[rptr[AW-1:0]] : '0;
  assign busy     = (state == LOAD);
  assign done     = (state == DONE);

  always_comb begin
    enc_word   = {`NOP, 14'd0};
    is_illegal = 1'b0;
    case (in_opcode)
      `NOP:    enc_word = {`NOP, 14'd0};
      `ADD:    enc_word = {`ADD, in_rd, in_rs, 8'h00};
      `ADDI:   enc_word = {`ADDI, in_rd, in_rs, in_imm};
      `LDI:    enc_word = {`LDI, in_rd, 3'd0, in_imm};
      default: is_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = LOAD;
      LOAD:       if (pop && (addr_max || (last_seen && one_left))) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wptr[AW-1:0]] <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      pm_addr   <= '0;
      ovf       <= 1'b0;
      last_seen <= 1'b0;
      illegal   <= 1'b0;
      err_count <= '0;
    end else begin
      illegal <= 1'b0;
      if (session_start) begin
        wptr      <= '0;
        rptr      <= '0;
        pm_addr   <= '0;
        ovf       <= 1'b0;
        last_seen <= 1'b0;
        err_count <= '0;
      end else if (state == LOAD) begin
        if (push) begin
          wptr <= wptr + PTR_ONE;
          if (in_last) last_seen <= 1'b1;
          if (is_illegal) begin
            illegal <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
        if (pop) begin
          rptr <= rptr + PTR_ONE;
          if (addr_max) begin
            // Overflow discards whatever is still queued, including a word pushed this cycle.
            ovf  <= 1'b1;
            wptr <= '0;
            rptr <= '0;
          end else begin
            pm_addr <= pm_addr + ADDR_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: scoreboard of expected writes checked as the DUT drains,
// plus a small-memory instance for the overflow path.
`ifndef OPCODES_SV
`include "opcodes.sv"
`endif

`define CHK(tag, obs, exp) \
  begin \
    tests++; \
    assert ((obs) === (exp)) else begin \
      fails++; \
      $error("FAIL %s: observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

module tb_instr_encoder;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, in_valid, in_ready, in_last;
  logic [5:0]  in_opcode;
  logic [2:0]  in_rd, in_rs;
  logic [7:0]  in_imm;
  logic        pm_we, pm_ready, busy, done, ovf, illegal;
  logic [8:0]  pm_addr;
  logic [19:0] pm_wdata;
  logic [7:0]  err_count;

  logic        start3, in_valid3, in_ready3, pm_we3, pm_ready3;
  logic        busy3, done3, ovf3, illegal3;
  logic [2:0]  pm_addr3;
  logic [19:0] pm_wdata3;
  logic [7:0]  err_count3;

  instr_encoder #(.PSIZE(9), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_imm(in_imm), .in_last(in_last),
    .pm_we(pm_we), .pm_ready(pm_ready), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .busy(busy), .done(done), .ovf(ovf), .illegal(illegal), .err_count(err_count)
  );

  instr_encoder #(.PSIZE(3), .DEPTH(4)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_opcode(`ADDI), .in_rd(3'd1), .in_rs(3'd2), .in_imm(8'h33), .in_last(1'b0),
    .pm_we(pm_we3), .pm_ready(pm_ready3), .pm_addr(pm_addr3), .pm_wdata(pm_wdata3),
    .busy(busy3), .done(done3), .ovf(ovf3), .illegal(illegal3), .err_count(err_count3)
  );

  logic [8:0]  sb_addr[$];
  logic [19:0] sb_data[$];
  logic [8:0]  exp_addr;
  int          wr3 = 0;

  always @(negedge clk) begin
    if (!reset && pm_we && pm_ready) begin
      if (sb_data.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_write: observed addr=%0h data=%0h expected no write", pm_addr, pm_wdata);
      end else begin
        logic [8:0]  ea;
        logic [19:0] ed;
        ea = sb_addr.pop_front();
        ed = sb_data.pop_front();
        `CHK("wr_addr", pm_addr, ea)
        `CHK("wr_data", pm_wdata, ed)
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && pm_we3 && pm_ready3) begin
      `CHK("ovf_wr_addr", pm_addr3, 3'(wr3))
      `CHK("ovf_wr_data", pm_wdata3, {`ADDI, 3'd1, 3'd2, 8'h33})
      wr3++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs,
                      input logic [7:0] imm, input logic last, input logic [19:0] word);
    int n = 0;
    in_opcode = op; in_rd = rd; in_rs = rs; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $error("FAIL accept_timeout: observed in_ready=0 expected 1 within 200 cycles");
    end else begin
      sb_addr.push_back(exp_addr);
      sb_data.push_back(word);
      exp_addr++;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb_data.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    `CHK("drain_complete", sb_data.size(), 0)
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [2:0]  r;
    logic [19:0] w0;
    int n;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_opcode = '0; in_rd = '0; in_rs = '0; in_imm = '0; pm_ready = 1'b1;
    start3 = 1'b0; in_valid3 = 1'b0; pm_ready3 = 1'b1;
    exp_addr = '0;
    tick(); tick();
    `CHK("rst_in_ready", in_ready, 1'b0)
    `CHK("rst_pm_we", pm_we, 1'b0)
    `CHK("rst_pm_addr", pm_addr, 9'd0)
    `CHK("rst_pm_wdata", pm_wdata, 20'd0)
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_done", done, 1'b0)
    `CHK("rst_ovf", ovf, 1'b0)
    `CHK("rst_illegal", illegal, 1'b0)
    `CHK("rst_err_count", err_count, 8'd0)
    reset = 1'b0;
    tick();

    // Two-instruction program ending on in_last.
    pulse_start();
    `CHK("start_busy", busy, 1'b1)
    `CHK("start_in_ready", in_ready, 1'b1)
    send(`ADD, 3'd2, 3'd3, 8'h55, 1'b0, {`ADD, 3'd2, 3'd3, 8'h00});
    `CHK("first_pm_we", pm_we, 1'b1)
    send(`LDI, 3'd1, 3'd5, 8'h7F, 1'b1, {`LDI, 3'd1, 3'd0, 8'h7F});
    `CHK("last_in_ready", in_ready, 1'b0)
    `CHK("done_not_yet", done, 1'b0)
    tick();
    `CHK("done_rise", done, 1'b1)
    `CHK("done_busy", busy, 1'b0)
    `CHK("done_queue", sb_data.size(), 0)

    // Backpressure: four ADDI words fill the FIFO while memory stalls.
    pm_ready = 1'b0;
    exp_addr = '0;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      r = 3'(i);
      send(`ADDI, r, 3'(7 - i), 8'(8'h10 + i), 1'b0, {`ADDI, r, 3'(7 - i), 8'(8'h10 + i)});
    end
    `CHK("full_in_ready", in_ready, 1'b0)
    w0 = {`ADDI, 3'd0, 3'd7, 8'h10};
    for (int i = 0; i < 3; i++) begin
      `CHK("stall_pm_we", pm_we, 1'b1)
      `CHK("stall_pm_addr", pm_addr, 9'd0)
      `CHK("stall_pm_wdata", pm_wdata, w0)
      tick();
    end
    pm_ready = 1'b1;
    tick(); tick(); tick(); tick();
    `CHK("drain4_queue", sb_data.size(), 0)
    `CHK("drain4_pm_we", pm_we, 1'b0)
    `CHK("drain4_pm_addr", pm_addr, 9'd4)

    // Illegal opcode in this session, then start during LOAD must be ignored.
    send(6'h3F, 3'd7, 3'd2, 8'hFF, 1'b0, {`NOP, 14'd0});
    `CHK("illegal_pulse", illegal, 1'b1)
    `CHK("illegal_count", err_count, 8'd1)
    tick();
    `CHK("illegal_clear", illegal, 1'b0)
    wait_empty();
    pulse_start();
    `CHK("ign_start_busy", busy, 1'b1)
    `CHK("ign_start_err", err_count, 8'd1)
    `CHK("ign_start_addr", pm_addr, 9'd5)
    send(`ADDI, 3'd6, 3'd1, 8'hA5, 1'b0, {`ADDI, 3'd6, 3'd1, 8'hA5});
    wait_empty();
    `CHK("ign_start_addr2", pm_addr, 9'd6)

    // Reset in the middle of a stalled load with three queued words.
    pm_ready = 1'b0;
    send(`ADDI, 3'd1, 3'd1, 8'h01, 1'b0, {`ADDI, 3'd1, 3'd1, 8'h01});
    send(`ADDI, 3'd2, 3'd2, 8'h02, 1'b0, {`ADDI, 3'd2, 3'd2, 8'h02});
    send(`ADDI, 3'd3, 3'd3, 8'h03, 1'b0, {`ADDI, 3'd3, 3'd3, 8'h03});
    `CHK("pre_rst_pm_we", pm_we, 1'b1)
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_addr.delete();
    sb_data.delete();
    `CHK("mid_rst_pm_we", pm_we, 1'b0)
    `CHK("mid_rst_busy", busy, 1'b0)
    `CHK("mid_rst_in_ready", in_ready, 1'b0)
    `CHK("mid_rst_pm_addr", pm_addr, 9'd0)
    `CHK("mid_rst_err", err_count, 8'd0)

    // Fresh session: 300 illegal opcodes saturate err_count.
    pm_ready = 1'b1;
    exp_addr = '0;
    pulse_start();
    `CHK("s3_busy", busy, 1'b1)
    `CHK("s3_pm_addr", pm_addr, 9'd0)
    send(6'h3F, 3'd7, 3'd5, 8'hFF, 1'b0, {`NOP, 14'd0});
    `CHK("s3_illegal_pulse", illegal, 1'b1)
    `CHK("s3_err_1", err_count, 8'd1)
    tick();
    `CHK("s3_illegal_clear", illegal, 1'b0)
    for (int i = 1; i < 300; i++)
      send(6'h3F, 3'd7, 3'd5, 8'hFF, 1'b0, {`NOP, 14'd0});
    wait_empty();
    `CHK("s3_err_sat", err_count, 8'd255)
    send(`ADD, 3'd4, 3'd4, 8'h99, 1'b1, {`ADD, 3'd4, 3'd4, 8'h00});
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    `CHK("s3_done", done, 1'b1)
    `CHK("s3_final_addr", pm_addr, 9'd301)

    // Small memory (PSIZE=3): ten words offered, only addresses 0-7 written.
    pulse3: begin
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      n = 0;
      in_valid3 = 1'b1;
      while (!in_ready3 && !done3 && n < 50) begin
        tick();
        n++;
      end
      if (done3) break;
      tick();
    end
    in_valid3 = 1'b0;
    n = 0;
    while (!done3 && n < 50) begin
      tick();
      n++;
    end
    tick(); tick(); tick();
    `CHK("ovf_writes", wr3, 8)
    `CHK("ovf_flag", ovf3, 1'b1)
    `CHK("ovf_done", done3, 1'b1)
    `CHK("ovf_in_ready", in_ready3, 1'b0)
    `CHK("ovf_pm_we", pm_we3, 1'b0)
    `CHK("ovf_addr_hold", pm_addr3, 3'd7)
    `CHK("ovf_err", err_count3, 8'd0)

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program-load encoder for picoMIPS, the write-side counterpart of the instruction decoder. It accepts instruction fields from a host or test harness over a valid/ready handshake and packs them into 20-bit instruction words, normalising fields per opcode. It buffers the words in a small FIFO and writes them to consecutive program-memory addresses starting at 0, reporting completion, overflow and illegal-opcode errors. Opcode values come from `opcodes.sv` (`` `NOP``, `` `ADD``, `` `ADDI``, `` `LDI``).

## Interface
- PSIZE, 6, program-memory address width
- DEPTH, 4, FIFO entries; power of 2, ≥2
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begins a load session; ignored unless in IDLE or DONE
- in_valid  in  1  field set valid
- in_ready  out  1  encoder accepts field set this cycle
- in_opcode  in  6  opcode
- in_rd  in  3  destination register
- in_rs  in  3  source register
- in_imm  in  8  immediate
- in_last  in  1  marks final instruction of the program
- pm_we  out  1  program-memory write request
- pm_ready  in  1  memory accepts write this cycle
- pm_addr  out  PSIZE  write address
- pm_wdata  out  20  instruction word {opcode[19:14], rd[13:11], rs[10:8], imm[7:0]}
- busy  out  1  high in LOAD
- done  out  1  high in DONE
- ovf  out  1  sticky: program exceeded memory
- illegal  out  1  one-cycle pulse per accepted illegal opcode
- err_count  out  8  illegal opcodes accepted this session, saturates at 255

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE/DONE --start--> LOAD; clears pm_addr, FIFO, ovf, err_count and the last-seen flag.
  - LOAD → DONE when the entry carrying in_last has been written, or on overflow.
- Handshake: `in_ready = (state==LOAD) && !fifo_full && !last_seen && !ovf`. A transfer occurs when in_valid && in_ready. A pop in the same cycle does not create room for a push; there is no bypass.
- Encoding is applied at acceptance:
  - `` `NOP``: word all fields zero except the opcode.
  - `` `ADD``: imm forced to 0.
  - `` `ADDI``: all fields kept.
  - `` `LDI``: rs forced to 0.
  - Any other opcode: encoded as `` `NOP`` word; illegal pulses the next cycle; err_count increments unless already 255.
- Drain: pm_we = !fifo_empty && state==LOAD. pm_wdata is the FIFO head. A write completes on pm_we && pm_ready; the FIFO pops and pm_addr increments.
- Overflow: completing a write at address 2^PSIZE−1 sets ovf. The FSM goes to DONE, the remaining FIFO contents are discarded (not counted as errors), and pm_addr holds at 2^PSIZE−1.
- Normal end: in_last accepted sets last_seen. When the FIFO empties after the last entry is written, the FSM goes to DONE.
- The last_seen flag and ovf hold the in_ready-low state until the next start.
- reset at any time: state IDLE, FIFO empty, pm_we 0 from the next cycle, and all outputs take their reset values. An in-flight write is abandoned.

## Timing
- Reset values: in_ready 0, pm_we 0, pm_addr 0, pm_wdata 0, busy 0, done 0, ovf 0, illegal 0, err_count 0.
- start sampled at cycle t → busy=1 and in_ready=1 at t+1.
- Latency: field set accepted at cycle t → pm_we=1 with its word at t+1, earliest.
- Throughput is 1 word/cycle with pm_ready held high and in_valid held high.
- pm_we, pm_addr and pm_wdata are stable while pm_we && !pm_ready.
- Final write completes at t → done=1 and busy=0 at t+1. done holds until the next start or reset.
- illegal is asserted exactly at t+1 for an acceptance at t.
- in_ready is registered/derived from state only, never combinationally from in_valid.

## Test plan
- Reset mid-LOAD with 3 FIFO entries, pm_ready=0 → next cycle pm_we=0, busy=0, in_ready=0, pm_addr=0. A subsequent start loads cleanly from address 0.
- start, then stream ADD rd=2 rs=3 imm=8'h55, LDI rd=1 rs=5 imm=8'h7F (last), with pm_ready=1 → two writes:
  - addr 0 = {`ADD,3'd2,3'd3,8'h00}
  - addr 1 = {`LDI,3'd1,3'd0,8'h7F}
  - done rises one cycle after the second write.
- pm_ready=0 while pushing DEPTH=4 ADDI words → in_ready drops after the 4th acceptance. pm_we/pm_addr/pm_wdata stay steady. Releasing pm_ready drains 4 words at addr 0–3 in 4 cycles.
- Opcode 6'h3F with rd=7 imm=8'hFF → `NOP word written, illegal pulse one cycle later, err_count=1. Repeat 300 times → err_count=255.
- PSIZE=3 with 10 instructions, no in_last → writes to addresses 0–7, then ovf=1, done=1, in_ready=0, and no further pm_we.
- start asserted during LOAD → ignored: pm_addr continues incrementing and err_count is not cleared.
